// File: rtl/nibble_alu_arbiter.sv
// Round-robin arbiter in front of one shared registered W-bit add/sub unit.
// Single-entry response register with valid/ready backpressure.
module nibble_alu_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_carry,
  output logic              busy,
  output logic [7:0]        op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] last_grant_reg;
  logic [W-1:0]   a_reg, b_reg;
  logic           op_reg;
  logic [IDW-1:0] id_reg;
  logic           rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [W-1:0]   rsp_result_reg;
  logic           rsp_carry_reg;
  logic [7:0]     op_count_reg;

  logic [W-1:0]   a_arr [NREQ];
  logic [W-1:0]   b_arr [NREQ];
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic [W:0]     sum;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
    end
  endgenerate

  // Walk candidates from farthest to nearest so the nearest valid one after
  // last_grant_reg is the final assignment and wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_grant_reg) + k) % NREQ);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Subtraction is A + ~B + 1, so the carry out doubles as "no borrow".
  assign sum = {1'b0, a_reg} + (op_reg ? {1'b0, ~b_reg} : {1'b0, b_reg})
             + {{W{1'b0}}, op_reg};

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (grant_found && !reset) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDW'(NREQ - 1);
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= 1'b0;
      id_reg         <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
      op_count_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && grant_found) begin
        a_reg          <= a_arr[grant_idx];
        b_reg          <= b_arr[grant_idx];
        op_reg         <= req_op[grant_idx];
        id_reg         <= grant_idx;
        last_grant_reg <= grant_idx;
      end
      if (state_reg == EXEC) begin
        rsp_result_reg <= sum[W-1:0];
        rsp_carry_reg  <= sum[W];
        rsp_id_reg     <= id_reg;
        rsp_valid_reg  <= 1'b1;
      end
      if (state_reg == RESP && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
        op_count_reg  <= op_count_reg + 8'd1;
      end
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_carry  = rsp_carry_reg;
  assign busy       = (state_reg != IDLE);
  assign op_count   = op_count_reg;

endmodule

// File: tb/tb_nibble_alu_arbiter.sv
// Directed bench for nibble_alu_arbiter: vector table plus hand-written
// fairness, backpressure, reset and counter-wrap sequences.
module tb_nibble_alu_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_carry;
  logic              busy;
  logic [7:0]        op_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  nibble_alu_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [3:0] exp_res;
    logic       exp_carry;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next falling edge, well away from the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b, input logic op);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_op[idx]       = op;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    step();
    reset = 1'b0;
    exp_count = 0;
    #1;
  endtask

  task automatic run_op(input int n, input vec_t v);
    logic [3:0] onehot;
    onehot = 4'b0001 << v.idx;
    req_valid = onehot;
    set_req(v.idx, v.a, v.b, v.op);
    rsp_ready = 1'b0;
    #1;
    chk("grant", {28'd0, req_ready}, {28'd0, onehot});
    chk("idle_busy", {31'd0, busy}, 32'd0);
    step();
    req_valid = '0;
    #1;
    chk("exec_ready", {28'd0, req_ready}, 32'd0);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    rsp_ready = 1'b1;
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_id", {30'd0, rsp_id}, v.idx);
    chk("rsp_result", {28'd0, rsp_result}, {28'd0, v.exp_res});
    chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, v.exp_carry});
    step();
    rsp_ready = 1'b0;
    exp_count++;
    #1;
    chk("op_count", {24'd0, op_count}, exp_count);
    chk("back_idle", {31'd0, rsp_valid}, 32'd0);
    $display("vec %0d: req%0d a=%h b=%h op=%0d -> result=%h carry=%0d", n, v.idx, v.a, v.b, v.op, rsp_result, rsp_carry);
  endtask

  initial begin
    vecs[0] = '{0, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
    vecs[1] = '{1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    vecs[2] = '{2, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0};
    vecs[3] = '{3, 4'h5, 4'h5, 1'b1, 4'h0, 1'b1};
    vecs[4] = '{0, 4'hA, 4'h3, 1'b1, 4'h7, 1'b1};
    vecs[5] = '{1, 4'h9, 4'h8, 1'b0, 4'h1, 1'b1};
    vecs[6] = '{2, 4'h0, 4'h1, 1'b1, 4'hF, 1'b0};
    vecs[7] = '{3, 4'h7, 4'h7, 1'b0, 4'hE, 1'b0};

    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    step();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_result", {28'd0, rsp_result}, 32'd0);
    chk("rst_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_carry", {31'd0, rsp_carry}, 32'd0);
    chk("rst_count", {24'd0, op_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) run_op(i, vecs[i]);

    // Fairness: all requesters pending, consumer always ready.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 1), 4'h1, 1'b0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      logic [3:0] exp_rdy;
      #1;
      exp_rdy = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      chk("fair_grant", {28'd0, req_ready}, {28'd0, exp_rdy});
      $display("fair cycle %0d: req_ready=%b", c, req_ready);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    chk("fair_count", {24'd0, op_count}, 32'd6);
    exp_count = 6;

    // Backpressure with req1 waiting behind a pending response.
    req_valid = 4'b0001;
    set_req(0, 4'h2, 4'h1, 1'b0);
    set_req(1, 4'h6, 4'h2, 1'b1);
    #1;
    chk("bp_grant0", {28'd0, req_ready}, 32'd1);
    step();
    req_valid = 4'b0010;
    #1;
    chk("bp_exec_ready", {28'd0, req_ready}, 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", {28'd0, rsp_result}, 32'd3);
      chk("bp_id", {30'd0, rsp_id}, 32'd0);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      $display("bp stall %0d: rsp_valid=%0d result=%h req_ready=%b", k, rsp_valid, rsp_result, req_ready);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
    step();
    rsp_ready = 1'b0;
    exp_count++;
    #1;
    chk("bp_grant1", {28'd0, req_ready}, 32'b0010);
    chk("bp_count", {24'd0, op_count}, exp_count);
    step();
    req_valid = '0;
    step();
    chk("bp_r1_result", {28'd0, rsp_result}, 32'd4);
    chk("bp_r1_carry", {31'd0, rsp_carry}, 32'd1);
    chk("bp_r1_id", {30'd0, rsp_id}, 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;

    // Asynchronous reset while EXEC holds req2's operation.
    req_valid = 4'b0100;
    set_req(2, 4'h1, 4'h1, 1'b0);
    #1;
    chk("ar_grant2", {28'd0, req_ready}, 32'b0100);
    step();
    req_valid = '0;
    reset = 1'b1;
    #1;
    chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ar_count", {24'd0, op_count}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    req_valid = 4'b1100;
    set_req(2, 4'h8, 4'h4, 1'b1);
    set_req(3, 4'h1, 4'h1, 1'b0);
    #1;
    chk("ar_ready_in_reset", {28'd0, req_ready}, 32'd0);
    step();
    chk("ar_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ar_first_grant", {28'd0, req_ready}, 32'b0100);
    step();
    req_valid = 4'b1000;
    #1;
    chk("ar_exec_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("ar_r2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ar_r2_id", {30'd0, rsp_id}, 32'd2);
    chk("ar_r2_result", {28'd0, rsp_result}, 32'd4);
    chk("ar_r2_carry", {31'd0, rsp_carry}, 32'd1);
    rsp_ready = 1'b1;
    step();
    chk("ar_count1", {24'd0, op_count}, 32'd1);
    chk("ar_grant3", {28'd0, req_ready}, 32'b1000);
    step();
    req_valid = '0;
    step();
    chk("ar_r3_id", {30'd0, rsp_id}, 32'd3);
    chk("ar_r3_result", {28'd0, rsp_result}, 32'd2);
    step();
    rsp_ready = 1'b0;

    // Counter wrap: one op every 3 cycles from reset.
    do_reset();
    req_valid = 4'b0001;
    set_req(0, 4'h1, 4'h2, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 1; i <= 768; i++) begin
      step();
      if (i == 765) begin
        chk("wrap_ff", {24'd0, op_count}, 32'hFF);
        $display("wrap: after 255 ops op_count=%h", op_count);
      end
      if (i == 768) begin
        chk("wrap_00", {24'd0, op_count}, 32'h00);
        $display("wrap: after 256 ops op_count=%h", op_count);
      end
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
